spi_clkgen: RTL



---
 rtl/spi_clkgen.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/spi_clkgen.sv
// Programmable SPI serial-clock generator: runtime half-period divider, CPOL select,
// fixed-length or continuous bursts, with leading/trailing edge strobes in the raw domain.
module spi_clkgen #(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic               raw,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [CNT_W-1:0]   div,
    input  logic [BURST_W-1:0] nbits,
    input  logic               cpol,
    output logic               sclk,
    output logic               lead_stb,
    output logic               trail_stb,
    output logic               busy,
    output logic               done
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   div_q, div_d;
    logic [BURST_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [BURST_W-1:0] nbits_q, nbits_d;
    logic [BURST_W-1:0] bit_inc;
    logic               cpol_q, cpol_d;
    logic               phase_q, phase_d;
    logic               stop_q, stop_d;
    logic               sclk_q, sclk_d;
    logic               lead_q, lead_d;
    logic               trail_q, trail_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               last_cycle;

    assign bit_inc = bit_cnt_q + BURST_W'(1);

    // A live stop counts on the very trailing edge it arrives with, not just the sticky copy.
    assign last_cycle = (nbits_q != '0) ? (bit_inc == nbits_q) : (stop_q | stop);

    always_ff @(posedge raw or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            bit_cnt_q <= '0;
            nbits_q   <= '0;
            cpol_q    <= 1'b0;
            phase_q   <= 1'b0;
            stop_q    <= 1'b0;
            sclk_q    <= 1'b0;
            lead_q    <= 1'b0;
            trail_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            nbits_q   <= nbits_d;
            cpol_q    <= cpol_d;
            phase_q   <= phase_d;
            stop_q    <= stop_d;
            sclk_q    <= sclk_d;
            lead_q    <= lead_d;
            trail_q   <= trail_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        nbits_d   = nbits_q;
        cpol_d    = cpol_q;
        phase_d   = phase_q;
        stop_d    = stop_q;
        sclk_d    = sclk_q;
        busy_d    = busy_q;
        lead_d    = 1'b0;
        trail_d   = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                sclk_d = cpol;
                busy_d = 1'b0;
                if (start) begin
                    div_d     = div;
                    nbits_d   = nbits;
                    cpol_d    = cpol;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    phase_d   = 1'b0;
                    stop_d    = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                busy_d = 1'b1;
                if (nbits_q == '0 && stop) begin
                    stop_d = 1'b1;
                end
                if (cnt_q == div_q) begin
                    cnt_d = '0;
                    if (!phase_q) begin
                        sclk_d  = ~cpol_q;
                        lead_d  = 1'b1;
                        phase_d = 1'b1;
                    end else begin
                        sclk_d    = cpol_q;
                        trail_d   = 1'b1;
                        phase_d   = 1'b0;
                        bit_cnt_d = bit_inc;
                        if (last_cycle) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            stop_d  = 1'b0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sclk      = sclk_q;
    assign lead_stb  = lead_q;
    assign trail_stb = trail_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
